// File: rtl/reset_sequencer.sv
// Reset sequencer: holds peripherals and core in reset, then releases them in order,
// restarting on watchdog or software requests and tracking request statistics.
module reset_sequencer #(
   parameter int unsigned ASSERT_CYCLES = 16,
   parameter int unsigned PERIPH_DELAY  = 8
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       I_WDT_RESET,
   input  logic       I_SW_RESET,
   input  logic       I_CLR_STATUS,
   output logic       O_PERIPH_RSTN,
   output logic       O_CORE_RSTN,
   output logic       O_RESET_DONE,
   output logic       O_BUSY,
   output logic [7:0] O_RESET_COUNT,
   output logic [1:0] O_LAST_CAUSE
);

   typedef enum logic [1:0] {StAssert, StPeriphRel, StCoreRel, StIdle} state_e;

   localparam logic [15:0] AssertLast = 16'(ASSERT_CYCLES - 1);
   localparam logic [15:0] PeriphLast = 16'(PERIPH_DELAY - 1);

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        periph_rstn_q, periph_rstn_d;
   logic        core_rstn_q, core_rstn_d;
   logic        done_q, done_d;
   logic        busy_q, busy_d;
   logic [7:0]  count_q, count_d;
   logic [1:0]  cause_q, cause_d;
   logic        req;
   logic        req_event;

   assign req       = I_WDT_RESET | I_SW_RESET;
   // Requests seen while already asserting only stretch the assert phase.
   assign req_event = req && (state_q != StAssert);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StAssert: begin
            if (cnt_q == AssertLast && !req) begin
               state_d = StPeriphRel;
               cnt_d   = '0;
            end else if (cnt_q != AssertLast) begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         StPeriphRel: begin
            if (req) begin
               state_d = StAssert;
               cnt_d   = '0;
            end else if (cnt_q == PeriphLast) begin
               state_d = StCoreRel;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         StCoreRel: begin
            state_d = req ? StAssert : StIdle;
            cnt_d   = '0;
         end
         StIdle: begin
            if (req) state_d = StAssert;
            cnt_d = '0;
         end
         default: begin
            state_d = StAssert;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so they change on the entering edge.
   always_comb begin
      periph_rstn_d = (state_d != StAssert);
      core_rstn_d   = (state_d == StCoreRel) || (state_d == StIdle);
      done_d        = (state_d == StCoreRel);
      busy_d        = (state_d != StIdle);
      count_d       = count_q;
      cause_d       = cause_q;
      if (I_CLR_STATUS) begin
         count_d = req_event ? 8'd1 : 8'd0;
      end else if (req_event && count_q != 8'hFF) begin
         count_d = count_q + 8'd1;
      end
      if (req_event) cause_d = {I_SW_RESET, I_WDT_RESET};
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= StAssert;
         cnt_q         <= '0;
         periph_rstn_q <= 1'b0;
         core_rstn_q   <= 1'b0;
         done_q        <= 1'b0;
         busy_q        <= 1'b1;
         count_q       <= '0;
         cause_q       <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         periph_rstn_q <= periph_rstn_d;
         core_rstn_q   <= core_rstn_d;
         done_q        <= done_d;
         busy_q        <= busy_d;
         count_q       <= count_d;
         cause_q       <= cause_d;
      end
   end

   assign O_PERIPH_RSTN = periph_rstn_q;
   assign O_CORE_RSTN   = core_rstn_q;
   assign O_RESET_DONE  = done_q;
   assign O_BUSY        = busy_q;
   assign O_RESET_COUNT = count_q;
   assign O_LAST_CAUSE  = cause_q;

endmodule
